// File: rtl/mac_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | mac_seq_pkg : shared state encodings, mode codes and defaults for the    |
// |               multi-cycle MAC sequencer.                                  |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package mac_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_ACC  = 3'd3,
        ST_RD_C = 3'd4,
        ST_WR   = 3'd5,
        ST_FIN  = 3'd6
    } state_e;

    localparam logic [1:0] MODE_DOT  = 2'b00;
    localparam logic [1:0] MODE_VMAC = 2'b01;

    localparam int DEFAULT_STRIDE = 4;

endpackage

`default_nettype wire

// File: rtl/mac_seq_alu.sv
// +--------------------------------------------------------------------------+
// | mac_seq_alu : combinational acc + a*b, wrapping by default or signed     |
// |               saturating when MAC_SAT_EN is defined.                      |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module mac_seq_alu #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o
);

`ifdef MAC_SAT_EN
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [2*DATA_W:0]   sum_s;
    logic        [DATA_W+1:0]   upper;

    assign prod_s = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i})
                  * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
    assign sum_s  = $signed({{(DATA_W+1){acc_i[DATA_W-1]}}, acc_i})
                  + $signed({prod_s[2*DATA_W-1], prod_s});
    // Result fits when every bit above the target sign bit matches it.
    assign upper  = sum_s[2*DATA_W:DATA_W-1];

    always_comb begin
        sum_o = sum_s[DATA_W-1:0];
        if (!((&upper) || !(|upper))) begin
            if (sum_s[2*DATA_W]) begin
                sum_o = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                sum_o = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end
`else
    assign sum_o = acc_i + a_i * b_i;
`endif

endmodule

`default_nettype wire

// File: rtl/mac_seq_unit.sv
// +--------------------------------------------------------------------------+
// | mac_seq_unit : DOT / VMAC multiply-accumulate sequencer owning a single  |
// |                data-memory port. Define MAC_SAT_EN for signed saturation.|
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module mac_seq_unit
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int STRIDE = DEFAULT_STRIDE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [ADDR_W-1:0] addr_c_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] result_o,
    output logic              data_mem_we_o,
    output logic [ADDR_W-1:0] data_mem_addr_o,
    output logic [DATA_W-1:0] data_mem_wdata_o,
    input  logic [DATA_W-1:0] data_mem_rdata_i,
    output logic [2:0]        state_o
);

    state_e              state_q, state_d;
    logic                vmac_q, vmac_d;
    logic                err_q, err_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pa_q, pa_d, pb_q, pb_d, pc_q, pc_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   alu_acc, alu_a, alu_b, alu_sum;

    mac_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .acc_i (alu_acc),
        .a_i   (alu_a),
        .b_i   (alu_b),
        .sum_o (alu_sum)
    );

    always_comb begin
        state_d  = state_q;
        vmac_d   = vmac_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        we_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        alu_acc  = acc_q;
        alu_a    = a_q;
        alu_b    = data_mem_rdata_i;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    vmac_d   = (mode_i == MODE_VMAC);
                    cnt_d    = len_i;
                    pa_d     = addr_a_i;
                    pb_d     = addr_b_i;
                    pc_d     = addr_c_i;
                    acc_d    = '0;
                    err_d    = mode_i[1];
                    result_d = '0;
                    if (mode_i[1] || (len_i == '0)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                addr_d  = pa_q;
                state_d = ST_RD_B;
            end
            ST_RD_B: begin
                a_d     = data_mem_rdata_i;
                addr_d  = pb_q;
                state_d = vmac_q ? ST_RD_C : ST_ACC;
            end
            ST_ACC: begin
                acc_d   = alu_sum;
                pa_d    = pa_q + ADDR_W'(STRIDE);
                pb_d    = pb_q + ADDR_W'(STRIDE);
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = (cnt_q == LEN_W'(1)) ? ST_RD_C : ST_RD_A;
            end
            ST_RD_C: begin
                if (vmac_q) begin
                    b_d = data_mem_rdata_i;
                end
                addr_d  = pc_q;
                state_d = ST_WR;
            end
            ST_WR: begin
                // DOT reuses the multiplier as mem[C] + acc*1.
                alu_acc  = data_mem_rdata_i;
                alu_a    = vmac_q ? a_q : acc_q;
                alu_b    = vmac_q ? b_q : DATA_W'(1);
                we_d     = 1'b1;
                addr_d   = pc_q;
                wdata_d  = alu_sum;
                result_d = alu_sum;
                if (vmac_q) begin
                    pa_d    = pa_q + ADDR_W'(STRIDE);
                    pb_d    = pb_q + ADDR_W'(STRIDE);
                    pc_d    = pc_q + ADDR_W'(STRIDE);
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? ST_FIN : ST_RD_A;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            vmac_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            pa_q     <= '0;
            pb_q     <= '0;
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            vmac_q   <= vmac_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = (state_q == ST_FIN);
    assign err_o            = (state_q == ST_FIN) && err_q;
    assign result_o         = result_q;
    assign data_mem_we_o    = we_q;
    assign data_mem_addr_o  = addr_q;
    assign data_mem_wdata_o = wdata_q;
    assign state_o          = state_q;

endmodule

`default_nettype wire
